// File: rtl/lns_pkg.sv
// Shared LNS definitions: word widths, saturation limits, the lns_t result word and the encoder FSM states.
// LIN2LNS_ROUND_EN adds a guard iteration for round-half-up results.
package lns_pkg;

   localparam int unsigned LIN_W    = 16;
   localparam int unsigned LIN_FRAC = 8;
   localparam int unsigned LOG_W    = 11;
   localparam int unsigned LOG_FRAC = 7;
   localparam int unsigned POS_W    = 4;
   localparam int unsigned INT_W    = 5;
   localparam int unsigned CNT_W    = 4;
`ifdef LIN2LNS_ROUND_EN
   localparam int unsigned ITER_N   = LOG_FRAC + 1;
`else
   localparam int unsigned ITER_N   = LOG_FRAC;
`endif
   localparam int LOG_MAX = 1023;
   localparam int LOG_MIN = -1024;

   typedef struct packed {
      logic                    sign;
      logic                    zero;
      logic signed [LOG_W-1:0] log;
   } lns_t;

   typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

endpackage

// File: rtl/lns_lod.sv
// Leading-one detector and normalizer: returns the MSB position, the 1.15 left-aligned mantissa and a zero flag.
module lns_lod
   import lns_pkg::*;
(
   input  logic [LIN_W-1:0] mag,
   output logic [POS_W-1:0] pos,
   output logic [LIN_W-1:0] mant,
   output logic             zero
);

   always_comb begin
      pos  = '0;
      zero = (mag == '0);
      for (int i = 0; i < LIN_W; i++) begin
         if (mag[i]) pos = POS_W'(i);
      end
      // A zero input is normalized to 1.0 so the squaring loop stays benign.
      if (zero) mant = {1'b1, (LIN_W-1)'(0)};
      else      mant = mag << (POS_W'(LIN_W-1) - pos);
   end

endmodule

// File: rtl/lin2lns_conv.sv
// Sequential linear-to-LNS encoder: LOD for the integer log, then one fractional bit per cycle by mantissa squaring.
// LIN2LNS_ROUND_EN: one extra guard iteration and round-half-up with saturation (latency 10 instead of 9).
module lin2lns_conv
   import lns_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [LIN_W-1:0] in_mag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic             out_zero,
   output logic [LOG_W-1:0] out_log
);

   localparam logic signed [LOG_W+1:0] SAT_HI = (LOG_W+2)'(LOG_MAX);
   localparam logic signed [LOG_W+1:0] SAT_LO = (LOG_W+2)'(LOG_MIN);

   state_t                    state, state_n;
   logic                      accept, norm, iter, publish, done_ack;
   logic [LIN_W-1:0]          mag_q, m_q, m_next, lod_mant;
   logic [POS_W-1:0]          lod_pos;
   logic                      lod_zero;
   logic                      sign_q, zero_q, sq_bit;
   logic signed [INT_W-1:0]   int_q;
   logic [ITER_N-1:0]         frac_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [2*LIN_W-1:0]        prod;
   logic signed [LOG_W+1:0]   res_base, res_wide;
   logic signed [LOG_W-1:0]   res_sat;
   lns_t                      res_q;

   lns_lod u_lod (
      .mag  (mag_q),
      .pos  (lod_pos),
      .mant (lod_mant),
      .zero (lod_zero)
   );

   // One squaring step: a product >= 2 yields a 1 bit and renormalizes by one position.
   always_comb begin
      prod   = (2*LIN_W)'(m_q) * (2*LIN_W)'(m_q);
      sq_bit = prod[2*LIN_W-1];
      m_next = sq_bit ? prod[2*LIN_W-1 -: LIN_W] : prod[2*LIN_W-2 -: LIN_W];
   end

   // Assemble int_part*128 + frac, optionally round on the guard bit, then saturate.
   always_comb begin
      res_base = $signed({{(LOG_W+2-INT_W-LOG_FRAC){int_q[INT_W-1]}}, int_q,
                          frac_q[ITER_N-1 -: LOG_FRAC]});
`ifdef LIN2LNS_ROUND_EN
      res_wide = res_base + $signed({{(LOG_W+1){1'b0}}, frac_q[0]});
`else
      res_wide = res_base;
`endif
      res_sat = LOG_W'(res_wide);
      if (res_wide > SAT_HI)      res_sat = LOG_W'(SAT_HI);
      else if (res_wide < SAT_LO) res_sat = LOG_W'(SAT_LO);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      accept   = 1'b0;
      norm     = 1'b0;
      iter     = 1'b0;
      publish  = 1'b0;
      done_ack = 1'b0;
      case (state)
         IDLE: if (in_valid && in_ready) begin
            accept  = 1'b1;
            state_n = NORM;
         end
         NORM: begin
            norm    = 1'b1;
            state_n = ITER;
         end
         ITER: begin
            iter = 1'b1;
            if (cnt_q == CNT_W'(1)) state_n = DONE;
         end
         DONE: begin
            if (!out_valid) publish = 1'b1;
            else if (out_ready) begin
               done_ack = 1'b1;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         res_q     <= '0;
         mag_q     <= '0;
         m_q       <= '0;
         sign_q    <= 1'b0;
         zero_q    <= 1'b0;
         int_q     <= '0;
         frac_q    <= '0;
         cnt_q     <= '0;
      end else begin
         in_ready <= (state_n == IDLE);
         if (accept) begin
            mag_q  <= in_mag;
            sign_q <= in_sign;
         end
         if (norm) begin
            m_q    <= lod_mant;
            zero_q <= lod_zero;
            int_q  <= lod_zero ? '0 : $signed(INT_W'(lod_pos) - INT_W'(LIN_FRAC));
            frac_q <= '0;
            cnt_q  <= CNT_W'(ITER_N);
         end
         if (iter) begin
            m_q    <= m_next;
            frac_q <= {frac_q[ITER_N-2:0], sq_bit};
            cnt_q  <= cnt_q - CNT_W'(1);
         end
         if (publish) begin
            out_valid  <= 1'b1;
            res_q.sign <= sign_q;
            res_q.zero <= zero_q;
            res_q.log  <= zero_q ? '0 : res_sat;
         end
         if (done_ack) out_valid <= 1'b0;
      end
   end

   assign out_sign = res_q.sign;
   assign out_zero = res_q.zero;
   assign out_log  = res_q.log;

endmodule

// File: tb/tb_lin2lns_conv.sv
// Self-checking bench for lin2lns_conv: directed corner cases plus random magnitudes against a real-valued log2 model.
module tb_lin2lns_conv;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_sign;
   logic [15:0] in_mag;
   logic        out_valid, out_ready, out_sign, out_zero;
   logic [10:0] out_log;

   int n_cmp = 0;
   int n_err = 0;

`ifdef LIN2LNS_ROUND_EN
   localparam int  LAT      = 10;
   localparam int  LOG_3    = 203;
   localparam real TOL_LO   = -0.5;
   localparam real TOL_HI   = 1.5;
`else
   localparam int  LAT      = 9;
   localparam int  LOG_3    = 202;
   localparam real TOL_LO   = -0.001;
   localparam real TOL_HI   = 1.05;
`endif

   lin2lns_conv dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_mag    (in_mag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_zero  (out_zero),
      .out_log   (out_log)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_tol(input string tag, input real got, input real ref_v);
      logic ok;
      real  err;
      err = ref_v - got;
      ok  = (err > TOL_LO) && (err < TOL_HI);
      n_cmp++;
      assert (ok === 1'b1) else begin
         n_err++;
         $error("FAIL %s: observed %f expected %f", tag, got, ref_v);
      end
   endtask

   // Launch one conversion; lat counts edges after the accept edge until out_valid.
   task automatic convert(input logic [15:0] mag, input logic sgn, output int lat);
      int w;
      w = 0;
      while (in_ready !== 1'b1 && w < 50) begin
         tick();
         w++;
      end
      in_valid = 1'b1;
      in_mag   = mag;
      in_sign  = sgn;
      tick();
      in_valid = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (out_valid !== 1'b1 && lat < 40);
   endtask

   task automatic ack();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] d_mag [6];
      logic        d_sgn [6];
      int          d_log [6];
      logic        d_zero[6];
      int          lat;
      real         ref_v;
      logic [15:0] rm;
      logic        rs;

      d_mag = '{16'h0100, 16'h0200, 16'h0001, 16'h0300, 16'hFFFF, 16'h0000};
      d_sgn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      d_log = '{0, 128, -1024, LOG_3, 1023, 0};
      d_zero = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_mag = '0; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_log", $signed(out_log), 0);
      chk("rst_out_sign", out_sign, 0);
      chk("rst_out_zero", out_zero, 0);
      rst = 1'b0;
      tick();

      // Directed corners: unity, powers of two, minimum, non-power, full scale, zero.
      for (int i = 0; i < 6; i++) begin
         convert(d_mag[i], d_sgn[i], lat);
         chk($sformatf("dir%0d_latency", i), lat, LAT);
         chk($sformatf("dir%0d_log", i), $signed(out_log), d_log[i]);
         chk($sformatf("dir%0d_zero", i), out_zero, d_zero[i]);
         chk($sformatf("dir%0d_sign", i), out_sign, d_sgn[i]);
         ack();
         chk($sformatf("dir%0d_valid_drop", i), out_valid, 0);
         chk($sformatf("dir%0d_ready_back", i), in_ready, 1);
      end

      // Back-pressure: result holds, input pulses are ignored while DONE waits.
      convert(16'h0200, 1'b1, lat);
      chk("bp_latency", lat, LAT);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_mag   = 16'($urandom_range(1, 65535));
         tick();
         chk($sformatf("bp%0d_valid", c), out_valid, 1);
         chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
         chk($sformatf("bp%0d_log", c), $signed(out_log), 128);
         chk($sformatf("bp%0d_sign", c), out_sign, 1);
      end
      ack();
      in_valid = 1'b0;
      chk("bp_ack_ready", in_ready, 1);
      chk("bp_ack_valid", out_valid, 0);
      repeat (12) tick();
      chk("bp_no_phantom", out_valid, 0);

      // Reset while iterating discards the conversion and clears the outputs.
      in_valid = 1'b1; in_mag = 16'hFFFF; in_sign = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      chk("midrst_valid", out_valid, 0);
      chk("midrst_log", $signed(out_log), 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_sign", out_sign, 0);
      rst = 1'b0;
      tick();
      convert(16'h0200, 1'b0, lat);
      chk("post_rst_latency", lat, LAT);
      chk("post_rst_log", $signed(out_log), 128);
      ack();

      // Random magnitudes spread over all octaves, against 128*log2(mag/256).
      for (int k = 0; k < 1500; k++) begin
         rm = 16'($urandom_range(1, 65535) >> $urandom_range(0, 15));
         if (rm == 16'h0000) rm = 16'h0001;
         rs = 1'($urandom_range(0, 1));
         convert(rm, rs, lat);
         ref_v = 128.0 * $ln(real'(rm) / 256.0) / $ln(2.0);
         chk_tol($sformatf("rnd%0d_log_mag%0h", k, rm), real'($signed(out_log)), ref_v);
         chk($sformatf("rnd%0d_latency", k), lat, LAT);
         chk($sformatf("rnd%0d_sign", k), out_sign, rs);
         chk($sformatf("rnd%0d_zero", k), out_zero, 0);
         ack();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
